// File: rtl/seq_det_pkg.sv
// +-----------------------------------------------------------------------+
// | seq_det_pkg : shared helpers for the programmable sequence detector   |
// | Rev 1.0     : initial release                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

package seq_det_pkg;

  localparam logic OVL_ON  = 1'b1;
  localparam logic OVL_OFF = 1'b0;

  function automatic int calc_len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  // Zero-length patterns degrade to single-bit matching; oversize ones clamp.
  function automatic int norm_len(input int len, input int max_len);
    if (len == 0)
      return 1;
    else if (len > max_len)
      return max_len;
    else
      return len;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_det_hist.sv
// +-----------------------------------------------------------------------+
// | seq_det_hist : history shift register and saturating fill counter     |
// | Rev 1.0      : initial release                                        |
// +-----------------------------------------------------------------------+
`default_nettype none

module seq_det_hist
  import seq_det_pkg::*;
#(
  parameter  int MAX_LEN = 8,
  localparam int LEN_W   = calc_len_w(MAX_LEN)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_shift,
  input  logic               i_clr,
  input  logic               i_x,
  output logic [MAX_LEN-2:0] o_hist,
  output logic [LEN_W-1:0]   o_fill
);

  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN - 1);

  logic [MAX_LEN-2:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic [MAX_LEN-2:0] w_hist_next;

  generate
    if (MAX_LEN == 2) begin : g_hist_one
      assign w_hist_next = i_x;
    end else begin : g_hist_wide
      assign w_hist_next = {r_hist[MAX_LEN-3:0], i_x};
    end
  endgenerate

  // Clear only touches fill; a non-overlap match still shifts its last bit in.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hist <= '0;
      r_fill <= '0;
    end else begin
      if (i_shift)
        r_hist <= w_hist_next;
      if (i_clr)
        r_fill <= '0;
      else if (i_shift && (r_fill != FILL_MAX))
        r_fill <= r_fill + LEN_W'(1);
    end
  end

  assign o_hist = r_hist;
  assign o_fill = r_fill;

endmodule

`default_nettype wire

// File: rtl/seq_detector_param.sv
// +-----------------------------------------------------------------------+
// | seq_detector_param : runtime-programmable serial pattern detector     |
// | Optional match counter enabled by defining SEQ_DET_COUNT_EN.          |
// | Rev 1.0            : initial release                                  |
// +-----------------------------------------------------------------------+
`default_nettype none

module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter  int                 MAX_LEN     = 8,
  parameter  int                 CNT_W       = 8,
  parameter  logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(8'b0000_0110),
  parameter  int                 RST_LEN     = 4,
  parameter  logic               RST_OVERLAP = OVL_ON,
  localparam int                 LEN_W       = calc_len_w(MAX_LEN)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_cfg_load,
  input  logic [MAX_LEN-1:0] i_cfg_pattern,
  input  logic [LEN_W-1:0]   i_cfg_len,
  input  logic               i_cfg_overlap,
  input  logic               i_x,
  input  logic               i_x_valid,
  input  logic               i_cnt_clr,
  output logic               o_z,
  output logic               o_z_q,
  output logic [CNT_W-1:0]   o_match_count
);

  logic [MAX_LEN-1:0] r_pat;
  logic [LEN_W-1:0]   r_len;
  logic               r_ovl;
  logic               r_z_q;

  logic [MAX_LEN-2:0] w_hist;
  logic [LEN_W-1:0]   w_fill;
  logic [MAX_LEN-1:0] w_window;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_accept;
  logic               w_filled;
  logic               w_z;
  logic               w_fill_clr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pat <= RST_PATTERN;
      r_len <= LEN_W'(norm_len(RST_LEN, MAX_LEN));
      r_ovl <= RST_OVERLAP;
    end else if (i_cfg_load) begin
      r_pat <= i_cfg_pattern;
      r_len <= LEN_W'(norm_len(int'(i_cfg_len), MAX_LEN));
      r_ovl <= i_cfg_overlap;
    end
  end

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < MAX_LEN; i++)
      w_mask[i] = (i < int'(r_len));
  end

  assign w_window   = {w_hist, i_x};
  assign w_accept   = i_x_valid & ~i_cfg_load;
  assign w_filled   = (w_fill >= (r_len - LEN_W'(1)));
  // Gated by reset so z drops the instant reset asserts, not at the next edge.
  assign w_z        = i_rst_n & w_accept & w_filled &
                      (((w_window ^ r_pat) & w_mask) == '0);
  assign w_fill_clr = i_cfg_load | (w_z & (r_ovl == OVL_OFF));

  seq_det_hist #(
    .MAX_LEN (MAX_LEN)
  ) u_hist (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_shift (w_accept),
    .i_clr   (w_fill_clr),
    .i_x     (i_x),
    .o_hist  (w_hist),
    .o_fill  (w_fill)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_z_q <= 1'b0;
    else
      r_z_q <= w_z;
  end

`ifdef SEQ_DET_COUNT_EN
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_cnt <= '0;
    else if (i_cnt_clr)
      r_cnt <= '0;
    else if (w_z && (r_cnt != '1))
      r_cnt <= r_cnt + CNT_W'(1);
  end

  assign o_match_count = r_cnt;
`else
  logic w_unused_cnt_clr;
  assign w_unused_cnt_clr = i_cnt_clr;
  assign o_match_count    = '0;
`endif

  assign o_z   = w_z;
  assign o_z_q = r_z_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_detector_param.sv
// +-----------------------------------------------------------------------+
// | tb_seq_detector_param : directed self-checking bench                  |
// | Rev 1.0               : initial release                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_seq_detector_param;

`ifdef SEQ_DET_COUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_load = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic       cfg_overlap = 1'b0;
  logic       x = 1'b0;
  logic       x_valid = 1'b0;
  logic       cnt_clr = 1'b0;
  logic       z, z_q, z2, z_q2;
  logic [7:0] cnt;
  logic [1:0] cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_detector_param dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cfg_load(cfg_load), .i_cfg_pattern(cfg_pattern),
    .i_cfg_len(cfg_len), .i_cfg_overlap(cfg_overlap), .i_x(x), .i_x_valid(x_valid),
    .i_cnt_clr(cnt_clr), .o_z(z), .o_z_q(z_q), .o_match_count(cnt)
  );

  seq_detector_param #(.CNT_W(2)) dut_c2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_cfg_load(cfg_load), .i_cfg_pattern(cfg_pattern),
    .i_cfg_len(cfg_len), .i_cfg_overlap(cfg_overlap), .i_x(x), .i_x_valid(x_valid),
    .i_cnt_clr(cnt_clr), .o_z(z2), .o_z_q(z_q2), .o_match_count(cnt2)
  );

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; cfg_load = 1'b0; x = 1'b0; x_valid = 1'b0; cnt_clr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send(input logic b, input logic v, input logic clr, output logic zobs);
    @(negedge clk);
    x = b; x_valid = v; cnt_clr = clr; cfg_load = 1'b0;
    #1 zobs = z;
    @(posedge clk);
    #1;
  endtask

  task automatic load_cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                          input logic b, input logic v, output logic zobs);
    @(negedge clk);
    cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl; cfg_load = 1'b1;
    x = b; x_valid = v; cnt_clr = 1'b0;
    #1 zobs = z;
    @(posedge clk);
    #1 cfg_load = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++; if (z !== 1'b0) begin n_fail++; $display("FAIL reset_z got=%b exp=0", z); end
    n_checks++; if (z_q !== 1'b0) begin n_fail++; $display("FAIL reset_zq got=%b exp=0", z_q); end
    n_checks++; if (cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
    n_checks++; if (dut.u_hist.o_fill !== 4'd0) begin n_fail++; $display("FAIL reset_fill got=%0d exp=0", dut.u_hist.o_fill); end
  endtask

  task automatic test_overlap();
    logic [0:11] s = 12'b0011_0110_0110;
    logic [0:11] e = 12'b0000_1001_0001;
    logic zo;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      send(s[i], 1'b1, 1'b0, zo);
      n_checks++; if (zo !== e[i]) begin n_fail++; $display("FAIL ovl_z bit%0d got=%b exp=%b", i+1, zo, e[i]); end
      n_checks++; if (z_q !== e[i]) begin n_fail++; $display("FAIL ovl_zq bit%0d got=%b exp=%b", i+1, z_q, e[i]); end
    end
    n_checks++; if (cnt !== (CNT_ON ? 8'd3 : 8'd0)) begin n_fail++; $display("FAIL ovl_cnt got=%0d exp=%0d", cnt, CNT_ON ? 3 : 0); end
  endtask

  task automatic test_non_overlap();
    logic [0:11] s = 12'b0011_0110_0110;
    logic [0:11] e = 12'b0000_1000_0001;
    logic zo;
    do_reset();
    load_cfg(8'b0000_0110, 4'd4, 1'b0, 1'b0, 1'b0, zo);
    for (int i = 0; i < 12; i++) begin
      send(s[i], 1'b1, 1'b0, zo);
      n_checks++; if (zo !== e[i]) begin n_fail++; $display("FAIL novl_z bit%0d got=%b exp=%b", i+1, zo, e[i]); end
    end
    n_checks++; if (cnt !== (CNT_ON ? 8'd2 : 8'd0)) begin n_fail++; $display("FAIL novl_cnt got=%0d exp=%0d", cnt, CNT_ON ? 2 : 0); end
  endtask

  task automatic test_len8_alt();
    logic [0:11] s = 12'b1010_1010_1010;
    logic [0:11] e = 12'b0000_0001_0101;
    logic zo;
    do_reset();
    load_cfg(8'b1010_1010, 4'd8, 1'b1, 1'b0, 1'b0, zo);
    for (int i = 0; i < 12; i++) begin
      send(s[i], 1'b1, 1'b0, zo);
      n_checks++; if (zo !== e[i]) begin n_fail++; $display("FAIL alt_z bit%0d got=%b exp=%b", i+1, zo, e[i]); end
    end
  endtask

  task automatic test_gaps();
    logic [0:11] s = 12'b0011_0110_0110;
    logic [0:11] e = 12'b0000_1001_0001;
    logic zo;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      send(s[i], 1'b1, 1'b0, zo);
      n_checks++; if (zo !== e[i]) begin n_fail++; $display("FAIL gap_z bit%0d got=%b exp=%b", i+1, zo, e[i]); end
      send(~s[i], 1'b0, 1'b0, zo);
      n_checks++; if (zo !== 1'b0 || z_q !== 1'b0) begin n_fail++; $display("FAIL gap_idle bit%0d got z=%b zq=%b exp=0", i+1, zo, z_q); end
    end
    n_checks++; if (cnt !== (CNT_ON ? 8'd3 : 8'd0)) begin n_fail++; $display("FAIL gap_cnt got=%0d exp=%0d", cnt, CNT_ON ? 3 : 0); end
  endtask

  task automatic test_len_bounds();
    logic [0:3] s0 = 4'b1011;
    logic [0:9] s8 = 10'b1100_1010_00;
    logic [0:9] e8 = 10'b0000_0001_00;
    logic zo;
    do_reset();
    load_cfg(8'b1111_0001, 4'd0, 1'b1, 1'b0, 1'b0, zo);
    for (int i = 0; i < 4; i++) begin
      send(s0[i], 1'b1, 1'b0, zo);
      n_checks++; if (zo !== s0[i]) begin n_fail++; $display("FAIL len0_z bit%0d got=%b exp=%b", i+1, zo, s0[i]); end
    end
    do_reset();
    load_cfg(8'b1100_1010, 4'd15, 1'b1, 1'b0, 1'b0, zo);
    for (int i = 0; i < 10; i++) begin
      send(s8[i], 1'b1, 1'b0, zo);
      n_checks++; if (zo !== e8[i]) begin n_fail++; $display("FAIL len15_z bit%0d got=%b exp=%b", i+1, zo, e8[i]); end
    end
  endtask

  task automatic test_load_on_last();
    logic [0:3] e = 4'b0001;
    logic [0:3] s = 4'b0110;
    logic zo;
    do_reset();
    send(1'b0, 1'b1, 1'b0, zo);
    send(1'b1, 1'b1, 1'b0, zo);
    send(1'b1, 1'b1, 1'b0, zo);
    load_cfg(8'b0000_0110, 4'd4, 1'b1, 1'b0, 1'b1, zo);
    n_checks++; if (zo !== 1'b0) begin n_fail++; $display("FAIL load_last_z got=%b exp=0", zo); end
    n_checks++; if (dut.u_hist.o_fill !== 4'd0) begin n_fail++; $display("FAIL load_last_fill got=%0d exp=0", dut.u_hist.o_fill); end
    for (int i = 0; i < 4; i++) begin
      send(s[i], 1'b1, 1'b0, zo);
      n_checks++; if (zo !== e[i]) begin n_fail++; $display("FAIL load_after_z bit%0d got=%b exp=%b", i+1, zo, e[i]); end
    end
  endtask

  task automatic test_counter();
    logic [0:15] s = 16'b0110_1101_1011_0110;
    logic zo;
    do_reset();
    for (int i = 0; i < 16; i++)
      send(s[i], 1'b1, 1'b0, zo);
    n_checks++; if (cnt !== (CNT_ON ? 8'd5 : 8'd0)) begin n_fail++; $display("FAIL cnt5 got=%0d exp=%0d", cnt, CNT_ON ? 5 : 0); end
    n_checks++; if (cnt2 !== (CNT_ON ? 2'd3 : 2'd0)) begin n_fail++; $display("FAIL cnt_sat got=%0d exp=%0d", cnt2, CNT_ON ? 3 : 0); end
    send(1'b1, 1'b1, 1'b0, zo);
    send(1'b1, 1'b1, 1'b0, zo);
    send(1'b0, 1'b1, 1'b1, zo);
    n_checks++; if (zo !== 1'b1) begin n_fail++; $display("FAIL clr_match_z got=%b exp=1", zo); end
    n_checks++; if (cnt !== 8'd0 || cnt2 !== 2'd0) begin n_fail++; $display("FAIL clr_wins got=%0d/%0d exp=0/0", cnt, cnt2); end
  endtask

  task automatic test_reset_mid();
    logic [0:3] s = 4'b0110;
    logic [0:3] e = 4'b0001;
    logic zo;
    do_reset();
    load_cfg(8'b0000_0001, 4'd1, 1'b1, 1'b0, 1'b0, zo);
    send(1'b1, 1'b1, 1'b0, zo);
    @(negedge clk);
    x = 1'b1; x_valid = 1'b1;
    #1;
    n_checks++; if (z !== 1'b1 || z_q !== 1'b1) begin n_fail++; $display("FAIL mid_pre got z=%b zq=%b exp=1/1", z, z_q); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (z !== 1'b0) begin n_fail++; $display("FAIL mid_z got=%b exp=0", z); end
    n_checks++; if (z_q !== 1'b0) begin n_fail++; $display("FAIL mid_zq got=%b exp=0", z_q); end
    n_checks++; if (dut.u_hist.o_fill !== 4'd0) begin n_fail++; $display("FAIL mid_fill got=%0d exp=0", dut.u_hist.o_fill); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(s[i], 1'b1, 1'b0, zo);
      n_checks++; if (zo !== e[i]) begin n_fail++; $display("FAIL mid_restart_z bit%0d got=%b exp=%b", i+1, zo, e[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_non_overlap();
    test_len8_alt();
    test_gaps();
    test_len_bounds();
    test_load_on_last();
    test_counter();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
